// File: rtl/snn_pkg.sv
// Shared SNN definitions: readout FSM states, default class/counter sizing, class index width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package snn_pkg;

  localparam int SNN_NUM_CLASSES = 10;
  localparam int SNN_CNT_W       = 8;
  localparam int CLS_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/winner_readout_sat_counter.sv
// Saturating up-counter for one output class.
// Latency: count updates on the edge after inc; clear wins over inc.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk_i clock, clear synchronous zero, inc count-enable, count current value.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk_i) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/winner_readout.sv
// Spike-count winner-take-all readout: counts spikes per class over WINDOW cycles, then scans for the max.
// Latency: start sampled at edge t -> valid_o in cycle t+WINDOW+NUM_CLASSES+1, single-cycle pulse.
// Backpressure: none; start_i ignored while busy_o, abort_i returns to idle at any time.
// Ports: clk_i/rst_i (sync, active-high), spike_i per-class spikes, start_i/abort_i control,
//        busy_o/valid_o status, class_o/count_o/tie_o result, sel_i/sel_count_o counter readback.
// Build option: define WINNER_READOUT_TIE_EN to compile in tie tracking for tie_o.
module winner_readout
  import snn_pkg::*;
#(
  parameter int NUM_CLASSES = SNN_NUM_CLASSES,
  parameter int CNT_W       = SNN_CNT_W,
  parameter int WINDOW      = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_CLASSES-1:0] spike_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic                   valid_o,
  output logic [CLS_W-1:0]       class_o,
  output logic [CNT_W-1:0]       count_o,
  output logic                   tie_o,
  input  logic [CLS_W-1:0]       sel_i,
  output logic [CNT_W-1:0]       sel_count_o
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt [NUM_CLASSES];
  logic [15:0]        win_cnt;
  logic [CLS_W-1:0]   scan_idx;
  logic [CLS_W-1:0]   best_idx, nb_idx;
  logic [CNT_W-1:0]   best_cnt, nb_cnt, cur_cnt;
  logic               start_clr, cnt_clear, cnt_en, win_last, scan_last;

  // Abort must not let a start in the same cycle wipe the counters.
  assign start_clr = (state == ST_IDLE) && start_i && !abort_i;
  assign cnt_clear = rst_i || start_clr;
  assign cnt_en    = (state == ST_COUNT) && !abort_i;
  assign win_last  = (win_cnt == 16'(WINDOW - 1));
  assign scan_last = (scan_idx == CLS_W'(NUM_CLASSES - 1));

  assign busy_o  = (state != ST_IDLE);
  assign valid_o = (state == ST_DONE);

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_cnt
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i (clk_i),
      .clear (cnt_clear),
      .inc   (cnt_en && spike_i[g]),
      .count (cnt[g])
    );
  end

  // Explicit compare-mux keeps the index width independent of NUM_CLASSES.
  always_comb begin
    cur_cnt     = '0;
    sel_count_o = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (scan_idx == CLS_W'(i)) cur_cnt = cnt[i];
      if (sel_i == CLS_W'(i))    sel_count_o = cnt[i];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_i)   state_nxt = ST_COUNT;
      ST_COUNT: if (win_last)  state_nxt = ST_SCAN;
      ST_SCAN:  if (scan_last) state_nxt = ST_DONE;
      ST_DONE:                 state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
    if (abort_i) state_nxt = ST_IDLE;
  end

  // Running best after examining scan_idx; index 0 seeds it, later classes
  // replace only on a strictly greater count so the lowest index keeps a tie.
  always_comb begin
    nb_idx = best_idx;
    nb_cnt = best_cnt;
    if (scan_idx == '0 || cur_cnt > best_cnt) begin
      nb_idx = scan_idx;
      nb_cnt = cur_cnt;
    end
  end

`ifdef WINNER_READOUT_TIE_EN
  logic tie_flag, nb_tie, tie_q;

  always_comb begin
    nb_tie = tie_flag;
    if (scan_idx == '0 || cur_cnt > best_cnt) nb_tie = 1'b0;
    else if (cur_cnt == best_cnt)             nb_tie = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tie_flag <= 1'b0;
      tie_q    <= 1'b0;
    end else if (state == ST_SCAN) begin
      tie_flag <= nb_tie;
      if (scan_last && !abort_i) tie_q <= nb_tie;
    end
  end

  assign tie_o = tie_q;
`else
  assign tie_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      win_cnt  <= '0;
      scan_idx <= '0;
      best_idx <= '0;
      best_cnt <= '0;
      class_o  <= '0;
      count_o  <= '0;
    end else begin
      state <= state_nxt;
      if (start_clr)               win_cnt <= '0;
      else if (state == ST_COUNT)  win_cnt <= win_cnt + 16'd1;
      if (state == ST_SCAN) begin
        scan_idx <= scan_idx + CLS_W'(1);
        best_idx <= nb_idx;
        best_cnt <= nb_cnt;
        // Results load only on the edge that enters DONE.
        if (scan_last && !abort_i) begin
          class_o <= nb_idx;
          count_o <= nb_cnt;
        end
      end else begin
        scan_idx <= '0;
      end
    end
  end

endmodule

// File: doc/winner_readout.md
WINNER_READOUT -- requirements
Module: winner_readout

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10, number of output-layer spike lines.
REQ-002 SHALL have parameter CNT_W, default 8, width of each per-class spike counter.
REQ-003 SHALL have parameter WINDOW, default 64, number of cycles in one counting window (legal range 1..65535).
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit, reset: synchronous, active-high.
REQ-006 SHALL have port spike_i, input, NUM_CLASSES bits, one spike flag per output neuron, sampled every cycle.
REQ-007 SHALL have port start_i, input, 1 bit, request to begin a classification window.
REQ-008 SHALL have port abort_i, input, 1 bit, cancels any window or scan in progress.
REQ-009 SHALL have port busy_o, output, 1 bit, high whenever the FSM is not in IDLE.
REQ-010 SHALL have port valid_o, output, 1 bit, single-cycle pulse marking a new result.
REQ-011 SHALL have port class_o, output, 4 bits, winning class index.
REQ-012 SHALL have port count_o, output, CNT_W bits, spike count of the winning class.
REQ-013 SHALL have port tie_o, output, 1 bit, another class equals the winning count.
REQ-014 SHALL have port sel_i, input, 4 bits, index of the counter to read back.
REQ-015 SHALL have port sel_count_o, output, CNT_W bits, combinational view of counter[sel_i]; 0 when sel_i >= NUM_CLASSES.

Function
REQ-016 SHALL implement FSM states IDLE, COUNT, SCAN, DONE.
REQ-017 SHALL move IDLE->COUNT on start_i, clear all counters and the window counter, and count no spikes in the start cycle.
REQ-018 SHALL ignore start_i in COUNT, SCAN and DONE.
REQ-019 SHALL, in COUNT, increment counter[i] by 1 each cycle spike_i[i]=1, saturating at 2^CNT_W-1.
REQ-020 SHALL count spikes in exactly WINDOW cycles, then move COUNT->SCAN.
REQ-021 SHALL, in SCAN, examine one class per cycle, index 0 to NUM_CLASSES-1, replacing the best only on strictly greater count, so the lowest index wins ties.
REQ-022 SHALL move SCAN->DONE after NUM_CLASSES cycles, then DONE->IDLE after one cycle.
REQ-023 SHALL assert valid_o only in DONE; with start sampled at edge t, valid_o is high in cycle t+WINDOW+NUM_CLASSES+1.
REQ-024 SHALL register class_o, count_o and tie_o on entry to DONE and hold them until the next DONE.
REQ-025 SHALL report class 0 with count 0 when all counters are zero (tie_o=1 when the tie feature is compiled in and NUM_CLASSES>1).
REQ-026 SHALL, on abort_i in any state, go to IDLE next cycle, produce no valid_o, keep the previous results, and freeze the counters; abort_i takes priority over start_i.
REQ-027 SHALL freeze the counters in IDLE, SCAN and DONE so sel_count_o stays readable after a window.

Reset
REQ-028 SHALL, on rst_i=1 at a clock edge, enter IDLE and zero all counters, the window counter, the scan index, class_o, count_o, tie_o, valid_o and busy_o.
REQ-029 SHALL give rst_i priority over abort_i and start_i, including in the middle of COUNT or SCAN.

Configuration
REQ-030 SHALL, with macro WINNER_READOUT_TIE_EN defined, track ties during SCAN: set on equal count, clear on strictly greater count, and drive tie_o from that flag.
REQ-031 SHALL, without WINNER_READOUT_TIE_EN, tie tie_o to constant 0 and omit the tie logic.

Structure
REQ-032 SHALL take the FSM state enum, default NUM_CLASSES and CNT_W, and the class index width (4) from the shared snn package.
REQ-033 SHALL instantiate the per-class counter as sub-module sat_counter (parameter CNT_W; inputs clear, inc; saturating).

Verification
REQ-034 SHALL be tested with WINDOW=64 and spike_i[3] high every cycle, all others 0 -> one valid_o at t+75, class_o=3, count_o=64, tie_o=0.
REQ-035 SHALL be tested with classes 2 and 7 spiking every cycle -> class_o=2, count_o=64, tie_o=1 with the macro and 0 without.
REQ-036 SHALL be tested with WINDOW=300 and CNT_W=8, class 5 always spiking -> count_o=255 (saturated), class_o=5.
REQ-037 SHALL be tested with abort_i at cycle 30 of COUNT -> busy_o low next cycle, no valid_o, previous results unchanged.
REQ-038 SHALL be tested with rst_i asserted during SCAN -> all outputs 0 next cycle, then a new start_i completes normally.
REQ-039 SHALL be tested with start_i held high throughout -> back-to-back windows, valid_o every WINDOW+NUM_CLASSES+2 cycles.
